// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 8x8 register file with two combinational read ports,
// one write-back port with write-through bypass, and a pending-write
// scoreboard that raises STALL on RAW/WAW hazards.
// Optional build macro: R0_ZERO_EN (R0 hardwired to zero, never pending).
module regfile_scoreboard #(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   RA_ADDR,
    input  logic [AW-1:0]   RB_ADDR,
    output logic [DW-1:0]   RA_DATA,
    output logic [DW-1:0]   RB_DATA,
    input  logic            WE,
    input  logic [AW-1:0]   WADDR,
    input  logic [DW-1:0]   WDATA,
    input  logic            ISSUE,
    input  logic            ISSUE_WR,
    input  logic [AW-1:0]   ISSUE_DST,
    input  logic            USE_A,
    input  logic            USE_B,
    output logic            STALL,
    output logic [NREG-1:0] PEND
);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic [NREG-1:0] wr_onehot;
    logic [NREG-1:0] eff_pend;
    logic            wr_ok;

    // Decode the write-back target; R0 writes are dropped when hardwired
    always_comb begin
        wr_ok = WE;
`ifdef R0_ZERO_EN
        if (WADDR == '0) wr_ok = 1'b0;
`endif
        wr_onehot = '0;
        if (WE) wr_onehot[WADDR] = 1'b1;
    end

    // Effective pending: a write landing this cycle resolves via the bypass
    always_comb begin
        eff_pend = pend_q & ~wr_onehot;
`ifdef R0_ZERO_EN
        eff_pend[0] = 1'b0;
`endif
    end

    // Hazard detection for the instruction presented by decode
    always_comb begin
        STALL = ISSUE && ((USE_A && eff_pend[RA_ADDR]) ||
                          (USE_B && eff_pend[RB_ADDR]) ||
                          (ISSUE_WR && eff_pend[ISSUE_DST]));
    end

    // Read ports with write-through bypass
    always_comb begin
        RA_DATA = regs_q[RA_ADDR];
        RB_DATA = regs_q[RB_ADDR];
        if (wr_ok && WADDR == RA_ADDR) RA_DATA = WDATA;
        if (wr_ok && WADDR == RB_ADDR) RB_DATA = WDATA;
`ifdef R0_ZERO_EN
        if (RA_ADDR == '0) RA_DATA = '0;
        if (RB_ADDR == '0) RB_DATA = '0;
`endif
    end

    // Next register-file contents
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
        if (wr_ok) regs_d[WADDR] = WDATA;
    end

    // Next scoreboard: clear on write-back, then set on issue (set wins)
    always_comb begin
        pend_d = pend_q & ~wr_onehot;
        if (ISSUE && ISSUE_WR && !STALL) pend_d[ISSUE_DST] = 1'b1;
`ifdef R0_ZERO_EN
        pend_d[0] = 1'b0;
`endif
    end

    // State registers, asynchronously cleared
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
            pend_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            pend_q <= pend_d;
        end
    end

    assign PEND = pend_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard; honours R0_ZERO_EN if defined.
module tb_regfile_scoreboard;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] RA_ADDR, RB_ADDR, WADDR, ISSUE_DST;
    logic [7:0] RA_DATA, RB_DATA, WDATA;
    logic       WE, ISSUE, ISSUE_WR, USE_A, USE_B, STALL;
    logic [7:0] PEND;

    int vectors = 0;
    int miscompares = 0;

    regfile_scoreboard #(.DW(8), .NREG(8), .AW(3)) dut (
        .CLK(CLK), .RST(RST),
        .RA_ADDR(RA_ADDR), .RB_ADDR(RB_ADDR),
        .RA_DATA(RA_DATA), .RB_DATA(RB_DATA),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .ISSUE(ISSUE), .ISSUE_WR(ISSUE_WR), .ISSUE_DST(ISSUE_DST),
        .USE_A(USE_A), .USE_B(USE_B),
        .STALL(STALL), .PEND(PEND)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        RA_ADDR = '0; RB_ADDR = '0; WADDR = '0; ISSUE_DST = '0; WDATA = '0;
        WE = 0; ISSUE = 0; ISSUE_WR = 0; USE_A = 0; USE_B = 0;
        #3;
        check("rst_pend", PEND, 8'h00);
        check("rst_stall", STALL, 1'b0);
        #4 RST = 1'b0;

        // T1: write R3, mark R1 pending, then asynchronous reset mid-cycle
        WE = 1; WADDR = 3; WDATA = 8'hA5;
        tick();
        WE = 0; RA_ADDR = 3; RB_ADDR = 3;
        ISSUE = 1; ISSUE_WR = 1; ISSUE_DST = 1;
        #1 check("t1_ra_a5", RA_DATA, 8'hA5);
        tick();
        ISSUE = 0; ISSUE_WR = 0;
        #1 check("t1_pend_set", PEND, 8'h02);
        #1 RST = 1'b1;
        ISSUE = 1; USE_A = 1; RA_ADDR = 1;
        #1;
        check("t1_pend_rst", PEND, 8'h00);
        check("t1_stall_rst", STALL, 1'b0);
        RA_ADDR = 3;
        #1;
        check("t1_ra_rst", RA_DATA, 8'h00);
        check("t1_rb_rst", RB_DATA, 8'h00);
        ISSUE = 0; USE_A = 0;
        #1 RST = 1'b0;
        tick();

        // T2: write-through bypass on both ports, then registered read
        WE = 1; WADDR = 2; WDATA = 8'h3C; RA_ADDR = 2; RB_ADDR = 2;
        #1;
        check("t2_ra_bypass", RA_DATA, 8'h3C);
        check("t2_rb_bypass", RB_DATA, 8'h3C);
        tick();
        WE = 0; WDATA = 8'h00;
        #1;
        check("t2_ra_stored", RA_DATA, 8'h3C);
        check("t2_pend_unch", PEND, 8'h00);

        // T3: RAW stall on R4, resolved by the write-back in the same cycle
        ISSUE = 1; ISSUE_WR = 1; ISSUE_DST = 4;
        #1 check("t3_issue_nostall", STALL, 1'b0);
        tick();
        check("t3_pend4", PEND, 8'h10);
        ISSUE_WR = 0; USE_A = 1; RA_ADDR = 4;
        #1 check("t3_raw_stall", STALL, 1'b1);
        tick();
        check("t3_stall_hold", STALL, 1'b1);
        check("t3_pend_hold", PEND, 8'h10);
        WE = 1; WADDR = 4; WDATA = 8'h11;
        #1;
        check("t3_stall_clear", STALL, 1'b0);
        check("t3_ra_bypass", RA_DATA, 8'h11);
        tick();
        ISSUE = 0; USE_A = 0; WE = 0;
        #1 check("t3_pend_clr", PEND, 8'h00);

        // T4: set beats clear on the same register
        ISSUE = 1; ISSUE_WR = 1; ISSUE_DST = 5;
        tick();
        check("t4_pend5", PEND, 8'h20);
        WE = 1; WADDR = 5; WDATA = 8'h55;
        #1 check("t4_nostall", STALL, 1'b0);
        tick();
        ISSUE = 0; ISSUE_WR = 0; WE = 0; RA_ADDR = 5;
        #1;
        check("t4_set_wins", PEND, 8'h20);
        check("t4_r5", RA_DATA, 8'h55);
        WE = 1; WADDR = 5; WDATA = 8'h56;
        tick();
        WE = 0;
        #1 check("t4_pend_clr", PEND, 8'h00);

        // T5: WAW stall leaves the scoreboard unchanged; port B hazard and USE gating
        ISSUE = 1; ISSUE_WR = 1; ISSUE_DST = 6;
        tick();
        check("t5_pend6", PEND, 8'h40);
        #1 check("t5_waw_stall", STALL, 1'b1);
        tick();
        check("t5_pend_unch", PEND, 8'h40);
        ISSUE_WR = 0; USE_B = 1; RB_ADDR = 6; RA_ADDR = 6;
        #1 check("t5_rb_stall", STALL, 1'b1);
        USE_B = 0;
        #1 check("t5_unused_nostall", STALL, 1'b0);
        ISSUE = 0;
        WE = 1; WADDR = 6; WDATA = 8'h66;
        tick();
        WE = 0;
        #1 check("t5_pend_clr", PEND, 8'h00);

        // T6: R0 behaviour depends on R0_ZERO_EN
        WE = 1; WADDR = 0; WDATA = 8'hFF; RA_ADDR = 0;
        #1;
`ifdef R0_ZERO_EN
        check("t6_r0_bypass", RA_DATA, 8'h00);
`else
        check("t6_r0_bypass", RA_DATA, 8'hFF);
`endif
        tick();
        WE = 0; WDATA = 8'h00;
        #1;
`ifdef R0_ZERO_EN
        check("t6_r0_read", RA_DATA, 8'h00);
`else
        check("t6_r0_read", RA_DATA, 8'hFF);
`endif
        ISSUE = 1; ISSUE_WR = 1; ISSUE_DST = 0;
        tick();
        ISSUE_WR = 0; USE_A = 1;
        #1;
`ifdef R0_ZERO_EN
        check("t6_pend0", PEND, 8'h00);
        check("t6_r0_stall", STALL, 1'b0);
`else
        check("t6_pend0", PEND, 8'h01);
        check("t6_r0_stall", STALL, 1'b1);
`endif
        ISSUE = 0; USE_A = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
